// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit FIFO.
// FSM state encoding and default parameter values.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    WAIT_DONE  = 2'd2
  } tx_state_e;

  localparam int DEPTH_LOG2_DEF    = 4;
  localparam int START_TIMEOUT_DEF = 8;

endpackage

// File: rtl/uart_fifo_mem.sv
// Byte RAM for the UART transmit FIFO.
// Synchronous write port, registered read port.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int AW = DEPTH_LOG2_DEF
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [2**AW];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter with a start/done handshake.
// Define UART_TX_FIFO_OVERFLOW_EN to add the sticky overflow flag.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2    = DEPTH_LOG2_DEF,
  parameter int START_TIMEOUT = START_TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [7:0]          wr_data,
  input  logic                is_transmitting,
  output logic [7:0]          tx_byte,
  output logic                transmit,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] count
`ifdef UART_TX_FIFO_OVERFLOW_EN
  ,
  output logic                overflow,
  input  logic                overflow_clr
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int TW    = $clog2(START_TIMEOUT + 1);

  tx_state_e state_q, state_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic [7:0] rd_data;
  logic transmit_q, transmit_d;
  logic rd_ok_q, rd_ok_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic push, pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = wr_en && !full;

  uart_fifo_mem #(
    .AW(DEPTH_LOG2)
  ) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr_q),
    .wdata(wr_data),
    .raddr(rd_ptr_q),
    .rdata(rd_data)
  );

  always_comb begin
    state_d    = state_q;
    tx_byte_d  = tx_byte_q;
    transmit_d = 1'b0;
    tmo_d      = tmo_q;
    pop        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty && rd_ok_q) begin
          pop        = 1'b1;
          tx_byte_d  = rd_data;
          transmit_d = 1'b1;
          tmo_d      = '0;
          state_d    = WAIT_START;
        end
      end
      WAIT_START: begin
        if (is_transmitting) begin
          state_d = WAIT_DONE;
        end else if (tmo_q == TW'(START_TIMEOUT - 1)) begin
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!is_transmitting) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(push);
    rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    // Registered read data matches rd_ptr one cycle after it settles.
    rd_ok_d  = (count_q != '0) && !pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_byte_q  <= 8'h00;
      transmit_q <= 1'b0;
      rd_ok_q    <= 1'b0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_byte_q  <= tx_byte_d;
      transmit_q <= transmit_d;
      rd_ok_q    <= rd_ok_d;
      tmo_q      <= tmo_d;
    end
  end

  assign tx_byte  = tx_byte_q;
  assign transmit = transmit_q;
  assign count    = count_q;

`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic overflow_q, overflow_d;

  always_comb begin
    overflow_d = overflow_q;
    if (wr_en && full)     overflow_d = 1'b1;
    else if (overflow_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow_q <= 1'b0;
    else        overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo with a transmitter BFM.
// Covers single byte, burst/overflow, wrap stream, timeout, mid-reset.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int DL    = 4;
  localparam int DEPTH = 16;
  localparam int TMO   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic is_tx = 1'b0;
  logic [7:0] tx_byte;
  logic transmit, full, empty;
  logic [DL:0] count;
`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic overflow;
  logic overflow_clr = 1'b0;
`endif

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DEPTH_LOG2(DL),
    .START_TIMEOUT(TMO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .is_transmitting(is_tx),
    .tx_byte        (tx_byte),
    .transmit       (transmit),
    .full           (full),
    .empty          (empty),
    .count          (count)
`ifdef UART_TX_FIFO_OVERFLOW_EN
    ,
    .overflow       (overflow),
    .overflow_clr   (overflow_clr)
`endif
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  byte unsigned exp_q[$];
  int mcnt = 0;
  bit movf = 1'b0;
  int tx_cyc_q[$];
  int ntx = 0;
  int bmode = 1;
  int hold = 0;
  bit arm = 1'b0;
  bit prev_tx = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a FIFO of at most DEPTH bytes, newest dropped when full.
  always @(posedge clk) begin
    cyc++;
    if (rst_n) begin
`ifdef UART_TX_FIFO_OVERFLOW_EN
      if (wr_en && mcnt >= DEPTH) movf = 1'b1;
      else if (overflow_clr)      movf = 1'b0;
`endif
      if (wr_en && mcnt < DEPTH) begin
        exp_q.push_back(wr_data);
        mcnt++;
      end
    end
  end

  // Monitor: every transmit pulse pops the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (transmit) begin
        tx_cyc_q.push_back(cyc);
        ntx++;
        chk("pulse_single", 32'(prev_tx), 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_tx", 32'(tx_byte), 32'hFFFF_FFFF);
        end else begin
          chk("tx_byte", 32'(tx_byte), 32'(exp_q.pop_front()));
          mcnt--;
        end
      end
      prev_tx = transmit;
      chk("count", 32'(count), 32'(mcnt));
      chk("full", 32'(full), 32'(mcnt == DEPTH));
      chk("empty", 32'(empty), 32'(mcnt == 0));
`ifdef UART_TX_FIFO_OVERFLOW_EN
      chk("overflow", 32'(overflow), 32'(movf));
`endif
    end
  end

  // Transmitter BFM: busy one clock after transmit, for a mode-dependent time.
  // bmode 0: never busy, 1: 10 clocks, 2: 1..4 clocks, 3: busy until mode changes.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      is_tx = 1'b0;
      arm = 1'b0;
      hold = 0;
    end else begin
      if (is_tx) begin
        if (bmode != 3) begin
          hold--;
          if (hold <= 0) is_tx = 1'b0;
        end
      end else if (arm) begin
        arm = 1'b0;
        is_tx = 1'b1;
        hold = (bmode == 2) ? int'($urandom_range(1, 4)) : 10;
      end
      if (transmit && bmode != 0) arm = 1'b1;
    end
  end

  task automatic wr(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic idle_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int lim);
    int k = 0;
    while ((exp_q.size() != 0 || is_tx || arm) && k < lim) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= lim) begin
      errors++;
      $display("FAIL drain: timeout after %0d cycles, %0d bytes left",
               k, exp_q.size());
    end
    idle_cyc(4);
  endtask

  task automatic wait_busy(input int lim);
    int k = 0;
    while (!is_tx && k < lim) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= lim) begin
      errors++;
      $display("FAIL wait_busy: timeout after %0d cycles", k);
    end
    idle_cyc(1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_tx_byte", 32'(tx_byte), 32'h00);
    chk("rst_transmit", 32'(transmit), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
`ifdef UART_TX_FIFO_OVERFLOW_EN
    chk("rst_overflow", 32'(overflow), 32'd0);
`endif
  endtask

  initial begin
    int acc;
    int n0;
    int nw;
    int it;
    idle_cyc(3);
    chk_reset_vals();
    rst_n = 1'b1;
    idle_cyc(2);

    // Single byte
    bmode = 1;
    tx_cyc_q.delete();
    wr(8'hA5);
    acc = cyc;
    drain(200);
    chk("single_pulses", 32'(tx_cyc_q.size()), 32'd1);
    if (tx_cyc_q.size() > 0)
      chk("single_latency", 32'(tx_cyc_q[0] - acc), 32'd2);
    chk("single_empty", 32'(empty), 32'd1);
    chk("single_state", 32'(dut.state_q), 32'(IDLE));

    // Burst behind a busy transmitter, then overflow
    bmode = 3;
    n0 = ntx;
    wr(8'h00);
    wait_busy(50);
    for (int i = 1; i <= DEPTH; i++) wr(8'(i));
    chk("burst_full", 32'(full), 32'd1);
    chk("burst_count", 32'(count), 32'd16);
    wr(8'hFF);
    chk("ovf_count", 32'(count), 32'd16);
`ifdef UART_TX_FIFO_OVERFLOW_EN
    chk("ovf_set", 32'(overflow), 32'd1);
    idle_cyc(2);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    overflow_clr = 1'b1;
    idle_cyc(1);
    overflow_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);
`endif
    bmode = 1;
    drain(1000);
    chk("burst_pulses", 32'(ntx - n0), 32'd17);

    // Random stream across pointer wrap with coincident push/pop
    bmode = 2;
    n0 = ntx;
    nw = 0;
    it = 0;
    while (nw < 40 && it < 2000) begin
      if ($urandom_range(0, 1) == 1 && mcnt < DEPTH - 2) begin
        wr(8'($urandom));
        nw++;
      end else begin
        idle_cyc(1);
      end
      it++;
    end
    chk("stream_writes", 32'(nw), 32'd40);
    drain(1000);
    chk("stream_pulses", 32'(ntx - n0), 32'd40);

    // Start timeout: transmitter never responds
    bmode = 0;
    tx_cyc_q.delete();
    wr(8'h11);
    wr(8'h22);
    drain(200);
    idle_cyc(TMO + 4);
    chk("tmo_pulses", 32'(tx_cyc_q.size()), 32'd2);
    if (tx_cyc_q.size() == 2)
      chk("tmo_spacing", 32'(tx_cyc_q[1] - tx_cyc_q[0]), 32'(TMO + 1));

    // Reset during WAIT_DONE with 5 bytes queued
    bmode = 3;
    for (int i = 0; i < 6; i++) wr(8'($urandom));
    wait_busy(50);
    idle_cyc(1);
    chk("mid_state", 32'(dut.state_q), 32'(WAIT_DONE));
    chk("mid_count", 32'(count), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    exp_q.delete();
    mcnt = 0;
    movf = 1'b0;
    prev_tx = 1'b0;
    bmode = 1;
    idle_cyc(3);
    rst_n = 1'b1;
    n0 = ntx;
    idle_cyc(30);
    chk("post_rst_pulses", 32'(ntx - n0), 32'd0);
    chk("post_rst_empty", 32'(empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL provide parameter DEPTH_LOG2, default 4, giving FIFO depth 2**DEPTH_LOG2 bytes (16).
REQ-002 SHALL provide parameter START_TIMEOUT, default 8, giving the maximum clocks to wait for is_transmitting after a transmit pulse.
REQ-003 SHALL have port clk  input  1  the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port wr_en  input  1  write strobe, driven by the receiver's received pulse.
REQ-006 SHALL have port wr_data  input  8  byte written when wr_en is accepted, driven by the receiver's rx_byte.
REQ-007 SHALL have port is_transmitting  input  1  busy flag from the UART transmitter.
REQ-008 SHALL have port tx_byte  output  8  registered byte presented to the UART transmitter.
REQ-009 SHALL have port transmit  output  1  registered single-cycle start pulse to the UART transmitter.
REQ-010 SHALL have port full  output  1  high when count equals depth.
REQ-011 SHALL have port empty  output  1  high when count is 0.
REQ-012 SHALL have port count  output  DEPTH_LOG2+1  stored-byte count.

Function
REQ-013 SHALL accept a write on a rising edge when wr_en=1 and full=0, storing wr_data at the write pointer and incrementing the pointer modulo depth.
REQ-014 SHALL ignore a write when wr_en=1 and full=1; stored contents and pointers are unchanged (drop-newest).
REQ-015 SHALL implement a 3-state FSM: IDLE, WAIT_START, WAIT_DONE.
REQ-016 In IDLE with empty=0, SHALL, on the next edge, load tx_byte from the read pointer, set transmit=1, increment the read pointer modulo depth, and enter WAIT_START.
REQ-017 In IDLE with empty=1, SHALL remain in IDLE with transmit=0.
REQ-018 SHALL drive transmit high for exactly one clock per popped byte.
REQ-019 In WAIT_START, SHALL enter WAIT_DONE on the first edge with is_transmitting=1, or enter IDLE after START_TIMEOUT clocks without it (byte considered lost).
REQ-020 In WAIT_DONE, SHALL hold tx_byte stable and enter IDLE on the first edge with is_transmitting=0.
REQ-021 SHALL assert transmit on the second rising edge after the edge that accepts a write into an empty FIFO while in IDLE.
REQ-022 On a same-edge write and pop, SHALL leave count unchanged and apply both pointer updates.
REQ-023 SHALL derive full, empty and count from registered state only; they are valid in the cycle after each edge.
REQ-024 SHALL wrap both pointers from depth-1 to 0 without any loss or duplication of data.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously force state=IDLE, both pointers=0, count=0, tx_byte=8'h00, transmit=0, full=0, empty=1.
REQ-026 SHALL discard FIFO contents and any in-flight handshake on reset mid-operation; the memory array itself need not be cleared.

Configuration
REQ-027 With UART_TX_FIFO_OVERFLOW_EN defined, SHALL add ports overflow (output 1, sticky, set on a dropped write) and overflow_clr (input 1, clears overflow on the next edge; a same-edge set wins), with overflow reset to 0.
REQ-028 Without UART_TX_FIFO_OVERFLOW_EN, SHALL have neither port and no overflow logic.

Structure
REQ-029 SHALL place the FSM state encoding typedef (IDLE=0, WAIT_START=1, WAIT_DONE=2) and default DEPTH_LOG2/START_TIMEOUT constants in shared package uart_pkg.
REQ-030 SHALL split storage into sub-module uart_fifo_mem: a dual-pointer byte RAM with synchronous write and registered read; the FSM stays in uart_tx_fifo.

Verification
REQ-031 Single byte: reset; write 8'hA5; BFM raises is_transmitting 1 clock after transmit and holds it 10 clocks -> transmit pulses once 2 edges after the write, tx_byte=8'hA5, empty=1 afterwards, state returns to IDLE.
REQ-032 Burst: write 8'h01..8'h10 back-to-back -> full=1 after the 16th write, count=16; the bytes are transmitted in order 01..10 with one pulse each, then empty=1.
REQ-033 Overflow: fill 16 bytes, write 8'hFF -> byte dropped and never transmitted; with UART_TX_FIFO_OVERFLOW_EN, overflow=1 until overflow_clr is pulsed.
REQ-034 Wrap and simultaneous events: stream 40 bytes with writes coinciding with pops -> count unchanged on coincident edges; output sequence matches input exactly across pointer wrap.
REQ-035 Timeout: BFM never raises is_transmitting -> FSM leaves WAIT_START after 8 clocks and the next byte pulses transmit.
REQ-036 Reset mid-transfer: assert rst_n=0 during WAIT_DONE with 5 bytes queued -> all outputs take reset values immediately; no transmit pulse follows release.
